// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    localparam int OP_DIV       = 0;
    localparam int OP_SIGNED    = 1;
    localparam int MULDIV_WIDTH = 16;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    input  logic               div,
    output logic [2*WIDTH-1:0] acc_nxt,
    output logic               qbit
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] top;
    logic [WIDTH:0] diff;

    always_comb begin
        sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        top  = acc[2*WIDTH-1:WIDTH-1];
        diff = top - {1'b0, opnd};
        // No borrow means the shifted remainder covers the divisor.
        qbit = div & ~diff[WIDTH];
        if (div) begin
            acc_nxt = {(qbit ? diff[WIDTH-1:0] : top[WIDTH-1:0]),
                       acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_nxt = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Fixed-latency multiply/divide sequencer for the Execute stage.
// MULDIV_SIGNED_EN enables signed ops (OpE[1]) and sign correction in FIX.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StartE,
    input  logic [1:0]       OpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             FlushE,
    output logic             BusyE,
    output logic             DoneE,
    output logic [WIDTH-1:0] ResultLoE,
    output logic [WIDTH-1:0] ResultHiE,
    output logic             DivZeroE
);

    localparam int CW = $clog2(WIDTH);

    state_t             state, state_n;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, acc_nxt, acc_ld;
    logic [WIDTH-1:0]   opnd, opnd_ld;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH-1:0]   lo_fix, hi_fix;
    logic               div_q, bz_q, qbit, accept;

`ifdef MULDIV_SIGNED_EN
    logic sgn, neg_lo, neg_hi;

    assign sgn   = OpE[OP_SIGNED];
    assign a_abs = (sgn & SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
    assign b_abs = (sgn & SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;
`else
    logic unused_sgn;

    assign unused_sgn = OpE[OP_SIGNED];
    assign a_abs      = SrcAE;
    assign b_abs      = SrcBE;
`endif

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc     (acc),
        .opnd    (opnd),
        .div     (div_q),
        .acc_nxt (acc_nxt),
        .qbit    (qbit)
    );

    assign accept = StartE & ~FlushE & ((state == IDLE) | (state == DONE));
    assign BusyE  = (state == RUN) | (state == FIX);
    assign DoneE  = (state == DONE);

    always_comb begin
        if (OpE[OP_DIV]) begin
            acc_ld  = {{WIDTH{1'b0}}, a_abs};
            opnd_ld = b_abs;
        end else begin
            acc_ld  = {{WIDTH{1'b0}}, b_abs};
            opnd_ld = a_abs;
        end
    end

    always_comb begin
        lo_fix = acc[WIDTH-1:0];
        hi_fix = acc[2*WIDTH-1:WIDTH];
`ifdef MULDIV_SIGNED_EN
        if (div_q) begin
            if (neg_lo) lo_fix = -acc[WIDTH-1:0];
            if (neg_hi) hi_fix = -acc[2*WIDTH-1:WIDTH];
            // Zero divisor: the remainder already carries the dividend.
            if (bz_q) lo_fix = '1;
        end else if (neg_lo) begin
            {hi_fix, lo_fix} = -acc;
        end
`endif
    end

    always_comb begin
        state_n = state;
        if (FlushE) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (StartE) state_n = RUN;
                RUN:  if (cnt == CW'(WIDTH - 1)) state_n = FIX;
                FIX:  state_n = DONE;
                DONE: state_n = StartE ? RUN : IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            opnd      <= '0;
            div_q     <= 1'b0;
            bz_q      <= 1'b0;
            ResultLoE <= '0;
            ResultHiE <= '0;
            DivZeroE  <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_lo    <= 1'b0;
            neg_hi    <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (accept) begin
                acc      <= acc_ld;
                opnd     <= opnd_ld;
                div_q    <= OpE[OP_DIV];
                bz_q     <= (SrcBE == '0);
                cnt      <= '0;
                DivZeroE <= 1'b0;
`ifdef MULDIV_SIGNED_EN
                neg_lo   <= sgn & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
                neg_hi   <= sgn & SrcAE[WIDTH-1];
`endif
            end else if (state == RUN) begin
                acc <= acc_nxt | {{(2*WIDTH-1){1'b0}}, qbit};
                cnt <= cnt + CW'(1);
            end
            if ((state == FIX) && !FlushE) begin
                ResultLoE <= lo_fix;
                ResultHiE <= hi_fix;
                DivZeroE  <= div_q & bz_q;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer (WIDTH=16).
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        StartE;
    logic [1:0]  OpE;
    logic [15:0] SrcAE;
    logic [15:0] SrcBE;
    logic        FlushE;
    logic        BusyE;
    logic        DoneE;
    logic [15:0] ResultLoE;
    logic [15:0] ResultHiE;
    logic        DivZeroE;

    int npass = 0;
    int ntot  = 0;

    muldiv_sequencer #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .StartE    (StartE),
        .OpE       (OpE),
        .SrcAE     (SrcAE),
        .SrcBE     (SrcBE),
        .FlushE    (FlushE),
        .BusyE     (BusyE),
        .DoneE     (DoneE),
        .ResultLoE (ResultLoE),
        .ResultHiE (ResultHiE),
        .DivZeroE  (DivZeroE)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b);
        StartE = 1'b1;
        OpE    = op;
        SrcAE  = a;
        SrcBE  = b;
        step();
        StartE = 1'b0;
        SrcAE  = 16'hDEAD;
        SrcBE  = 16'hBEEF;
    endtask

    // Leaves the bench in the DoneE cycle (or at the cycle bound).
    task automatic wait_done(input bit poke, output int n, output int nb);
        n  = 1;
        nb = 0;
        while (!DoneE && n < 40) begin
            if (BusyE) nb++;
            StartE = poke && (n == 3);
            step();
            n++;
        end
        StartE = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] elo, input logic [15:0] ehi,
                          input logic edz, input bit poke);
        int n, nb;
        start(op, a, b);
        wait_done(poke, n, nb);
        check({tag, "_lo"}, 32'(ResultLoE), 32'(elo));
        check({tag, "_hi"}, 32'(ResultHiE), 32'(ehi));
        check({tag, "_dz"}, 32'(DivZeroE), 32'(edz));
        check({tag, "_lat"}, n, 18);
        check({tag, "_busy"}, nb, 17);
    endtask

    initial begin
        int dones;
        reset  = 1'b1;
        StartE = 1'b0;
        FlushE = 1'b0;
        OpE    = 2'b00;
        SrcAE  = '0;
        SrcBE  = '0;
        repeat (2) step();
        reset = 1'b0;
        step();
        check("rst_busy", 32'(BusyE), 0);
        check("rst_done", 32'(DoneE), 0);
        check("rst_lo", 32'(ResultLoE), 0);
        check("rst_hi", 32'(ResultHiE), 0);
        check("rst_dz", 32'(DivZeroE), 0);

        run_op("mul300x200", 2'b00, 16'd300, 16'd200, 16'hEA60, 16'h0000, 0, 0);
        run_op("mulffff", 2'b00, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 0, 0);
        run_op("div100_7", 2'b01, 16'd100, 16'd7, 16'd14, 16'd2, 0, 1);
        run_op("div_by0", 2'b01, 16'd1234, 16'd0, 16'hFFFF, 16'h04D2, 1, 0);
        run_op("div_after0", 2'b01, 16'd1000, 16'd10, 16'd100, 16'd0, 0, 0);
`ifdef MULDIV_SIGNED_EN
        run_op("sdiv", 2'b11, 16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 0, 0);
        run_op("sovf", 2'b11, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 0, 0);
        run_op("smul", 2'b10, 16'hFFFD, 16'd5, 16'hFFF1, 16'hFFFF, 0, 0);
        run_op("sdiv0", 2'b11, 16'hFFF9, 16'd0, 16'hFFFF, 16'hFFF9, 1, 0);
`else
        run_op("udiv_op1", 2'b11, 16'hFFF9, 16'd2, 16'h7FFC, 16'h0001, 0, 0);
        run_op("umul_op1", 2'b10, 16'hFFFD, 16'd5, 16'hFFF1, 16'h0004, 0, 0);
`endif

        run_op("b2b_a", 2'b00, 16'd3, 16'd4, 16'd12, 16'd0, 0, 0);
        run_op("b2b_b", 2'b00, 16'd7, 16'd9, 16'd63, 16'd0, 0, 0);
        step();
        check("done_pulse", 32'(DoneE), 0);
        check("idle_busy", 32'(BusyE), 0);

        start(2'b00, 16'd300, 16'd200);
        repeat (4) step();
        FlushE = 1'b1;
        step();
        FlushE = 1'b0;
        check("flush_idle", 32'(BusyE), 0);
        dones = 0;
        repeat (25) begin
            if (DoneE) dones++;
            step();
        end
        check("flush_nodone", dones, 0);
        check("flush_lo", 32'(ResultLoE), 32'd63);
        check("flush_hi", 32'(ResultHiE), 32'd0);

        StartE = 1'b1;
        FlushE = 1'b1;
        OpE    = 2'b00;
        SrcAE  = 16'd5;
        SrcBE  = 16'd5;
        step();
        StartE = 1'b0;
        FlushE = 1'b0;
        check("flush_wins", 32'(BusyE), 0);

        start(2'b00, 16'hFFFF, 16'hFFFF);
        repeat (9) step();
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(BusyE), 0);
        check("mid_rst_done", 32'(DoneE), 0);
        check("mid_rst_lo", 32'(ResultLoE), 0);
        check("mid_rst_hi", 32'(ResultHiE), 0);
        check("mid_rst_dz", 32'(DivZeroE), 0);
        step();
        reset = 1'b0;
        step();
        run_op("post_rst", 2'b01, 16'd100, 16'd7, 16'd14, 16'd2, 0, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
